uart_rx_core: RTL

Oversampling UART receiver datapath: recovers serial frames on `rx` into parallel bytes, one per frame.
- Frame format: 1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit.
- Counterpart of the transmitter. Sits between the serial line and the receive buffer in the UART top, clocked by UCLK.
- Bit timing comes from the shared baud generator's BCLK oversample tick.

---
 rtl/uart_rx_core.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: start + DATA_WIDTH data bits (LSB first) + stop, mid-bit sampling on BCLK ticks.
// Optional even-parity bit and parity_err output when UART_RX_PARITY_EN is defined.
module uart_rx_core #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DATA_BITS  = $clog2(DATA_WIDTH)
) (
  input  logic                  UCLK,
  input  logic                  reset,
  input  logic                  BCLK,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] R_data,
  output logic                  rx_done,
  output logic                  frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                  parity_err,
`endif
  output logic                  rx_busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0]    TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0]    TICK_FULL = TICK_W'(OVERSAMPLE - 1);
  localparam logic [DATA_BITS-1:0] LAST_BIT  = DATA_BITS'(DATA_WIDTH - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                state, state_nxt;
  logic                  rx_meta, rx_s;
  logic [TICK_W-1:0]     tick_cnt;
  logic [DATA_BITS-1:0]  bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  bit_end, sample_data, sample_stop;
  logic                  at_half, at_full;
`ifdef UART_RX_PARITY_EN
  logic                  par_bit, sample_par;
`endif

  assign at_half = (tick_cnt == TICK_HALF);
  assign at_full = (tick_cnt == TICK_FULL);

  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!rx_s) state_nxt = START;
      START: if (BCLK && at_half) state_nxt = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (BCLK && at_full && bit_cnt == LAST_BIT) state_nxt = PARITY;
      PARITY: if (BCLK && at_full) state_nxt = STOP;
`else
      DATA:  if (BCLK && at_full && bit_cnt == LAST_BIT) state_nxt = STOP;
`endif
      STOP:  if (BCLK && at_full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rx_busy     = (state != IDLE);
    bit_end     = 1'b0;
    sample_data = 1'b0;
    sample_stop = 1'b0;
`ifdef UART_RX_PARITY_EN
    sample_par  = 1'b0;
`endif
    if (BCLK) begin
      case (state)
        START: bit_end = at_half;
        DATA: begin
          bit_end     = at_full;
          sample_data = at_full;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          bit_end    = at_full;
          sample_par = at_full;
        end
`endif
        STOP: begin
          bit_end     = at_full;
          sample_stop = at_full;
        end
        default: bit_end = 1'b0;
      endcase
    end
  end

  // Tick counter restarts at every bit boundary so each sample lands mid-bit.
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      if (state == IDLE)  tick_cnt <= '0;
      else if (BCLK)      tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
      if (state == START) bit_cnt <= '0;
      else if (sample_data) bit_cnt <= bit_cnt + 1'b1;
      if (sample_data) shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      R_data     <= '0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_done <= sample_stop;
`ifdef UART_RX_PARITY_EN
      if (sample_par) par_bit <= rx_s;
`endif
      if (sample_stop) begin
        R_data    <= shreg;
        frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
        parity_err <= (^shreg) ^ par_bit;
`endif
      end
    end
  end

endmodule
